// File: rtl/conv_anchor_ctrl_pkg.sv
// Shared definitions for the convolution anchor sequencer: FSM state encodings
// and the output-dimension helper used for elaboration-time parameter checks.
package conv_anchor_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of output positions along one axis for a valid (non-dilated) convolution.
  function automatic int conv_out_dim(input int img, input int wgt, input int strd, input int pad);
    return (img + 2 * pad - wgt) / strd + 1;
  endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Row-major 2-D position counter for the anchor sequencer: advances one column
// per enable, wraps to the next row, and flags the final position.
module conv_pos_counter
  import conv_anchor_ctrl_pkg::*;
#(
  parameter int rows  = 2,
  parameter int cols  = 2,
  parameter int idx_w = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [idx_w-1:0] row_idx,
  output logic [idx_w-1:0] col_idx,
  output logic             last
);

  localparam logic [idx_w-1:0] last_row = idx_w'(rows - 1);
  localparam logic [idx_w-1:0] last_col = idx_w'(cols - 1);
  localparam logic [idx_w-1:0] one_w    = idx_w'(1);

  logic [idx_w-1:0] row_reg;
  logic [idx_w-1:0] col_reg;

  assign row_idx = row_reg;
  assign col_idx = col_reg;
  assign last    = (row_reg == last_row) && (col_reg == last_col);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (en) begin
      if (col_reg == last_col) begin
        col_reg <= '0;
        // Wrapping past the last row returns the counter to the origin.
        row_reg <= (row_reg == last_row) ? '0 : row_reg + one_w;
      end else begin
        col_reg <= col_reg + one_w;
      end
    end
  end

endmodule

// File: rtl/conv_anchor_ctrl.sv
// Window sequencer: steps anchors over every output position, captures one
// float16 result per position. Build option: CONV_RESULT_RELU_EN clamps negatives to 0.
module conv_anchor_ctrl
  import conv_anchor_ctrl_pkg::*;
#(
  parameter int data_width    = 16,
  parameter int image_length  = 4,
  parameter int image_width   = 4,
  parameter int weight_length = 3,
  parameter int weight_width  = 3,
  parameter int stride        = 1,
  parameter int padding       = 0,
  parameter int result_length = 2,
  parameter int result_width  = 2
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               start,
  input  logic                                               pe_valid,
  input  logic [data_width-1:0]                              pe_result,
  output logic                                               conv_en,
  output logic [data_width-1:0]                              anchor_2D,
  output logic [data_width-1:0]                              anchor_1D,
  output logic                                               busy,
  output logic                                               done,
  output logic [0:result_width*result_length*data_width-1]   result
);

  localparam int num_slots = result_width * result_length;
  localparam logic [data_width-1:0] stride_w  = data_width'(stride);
  localparam logic [data_width-1:0] one_w     = data_width'(1);
  localparam logic [data_width-1:0] last_col  = data_width'(result_length - 1);
  localparam logic [data_width-1:0] row_pitch = data_width'(result_length);

  if (conv_out_dim(image_length, weight_length, stride, padding) != result_length) begin : g_bad_length
    $error("result_length does not match image_length/weight_length/stride/padding");
  end
  if (conv_out_dim(image_width, weight_width, stride, padding) != result_width) begin : g_bad_width
    $error("result_width does not match image_width/weight_width/stride/padding");
  end

  state_t state_reg, state_next;

  logic                  conv_en_reg, conv_en_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic [data_width-1:0] anchor_2D_reg, anchor_2D_next;
  logic [data_width-1:0] anchor_1D_reg, anchor_1D_next;

  logic [data_width-1:0] row_idx, col_idx;
  logic                  pos_last;
  logic                  capture, start_accept;
  logic [data_width-1:0] slot_idx;
  logic [data_width-1:0] capture_data;

  assign capture      = (state_reg == RUN) && pe_valid;
  assign start_accept = (state_reg == IDLE) && start;
  assign slot_idx     = row_idx * row_pitch + col_idx;

`ifdef CONV_RESULT_RELU_EN
  assign capture_data = pe_result[data_width-1] ? '0 : pe_result;
`else
  assign capture_data = pe_result;
`endif

  conv_pos_counter #(
    .rows  (result_width),
    .cols  (result_length),
    .idx_w (data_width)
  ) u_pos_counter (
    .clk     (clk),
    .reset   (reset),
    .clr     (start_accept || (state_reg == DONE)),
    .en      (capture),
    .row_idx (row_idx),
    .col_idx (col_idx),
    .last    (pos_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      conv_en_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      anchor_2D_reg <= '0;
      anchor_1D_reg <= '0;
    end else begin
      state_reg     <= state_next;
      conv_en_reg   <= conv_en_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      anchor_2D_reg <= anchor_2D_next;
      anchor_1D_reg <= anchor_1D_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (pe_valid && pos_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    conv_en_next   = (state_next == RUN);
    busy_next      = (state_next == RUN);
    done_next      = (state_next == DONE);
    anchor_2D_next = anchor_2D_reg;
    anchor_1D_next = anchor_1D_reg;
    if (state_next != RUN || start_accept) begin
      anchor_2D_next = '0;
      anchor_1D_next = '0;
    end else if (capture) begin
      if (col_idx == last_col) begin
        anchor_1D_next = '0;
        anchor_2D_next = (row_idx + one_w) * stride_w;
      end else begin
        anchor_1D_next = (col_idx + one_w) * stride_w;
      end
    end
  end

  assign conv_en   = conv_en_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign anchor_2D = anchor_2D_reg;
  assign anchor_1D = anchor_1D_reg;

  // Element 0 sits at the most significant end of the ascending result vector.
  for (genvar gi = 0; gi < num_slots; gi++) begin : g_slot
    logic [data_width-1:0] slot_reg;
    always_ff @(posedge clk) begin
      if (reset || start_accept) begin
        slot_reg <= '0;
      end else if (capture && (slot_idx == data_width'(gi))) begin
        slot_reg <= capture_data;
      end
    end
    assign result[gi*data_width +: data_width] = slot_reg;
  end

endmodule

// File: tb/tb_conv_anchor_ctrl.sv
// Directed bench for conv_anchor_ctrl: default 4x4/3x3 map plus a 5x5 stride-2
// instance; expectations follow CONV_RESULT_RELU_EN when it is defined.
module tb_conv_anchor_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, pe_valid = 1'b0;
  logic [15:0] pe_result = '0;
  logic        conv_en, busy, done;
  logic [15:0] anchor_2D, anchor_1D;
  logic [0:63] result;

  logic        start5 = 1'b0, pe_valid5 = 1'b0;
  logic [15:0] pe_result5 = '0;
  logic        conv_en5, busy5, done5;
  logic [15:0] anchor_2D5, anchor_1D5;
  logic [0:63] result5;

  int tests = 0;
  int fails = 0;
  logic [15:0] neg_exp;
  logic [15:0] exp_r5 [4];
  logic [15:0] exp_c5 [4];

  always #5 clk = ~clk;

  conv_anchor_ctrl u_dut (
    .clk(clk), .reset(reset), .start(start), .pe_valid(pe_valid), .pe_result(pe_result),
    .conv_en(conv_en), .anchor_2D(anchor_2D), .anchor_1D(anchor_1D),
    .busy(busy), .done(done), .result(result)
  );

  conv_anchor_ctrl #(.image_length(5), .image_width(5), .stride(2)) u_dut5 (
    .clk(clk), .reset(reset), .start(start5), .pe_valid(pe_valid5), .pe_result(pe_result5),
    .conv_en(conv_en5), .anchor_2D(anchor_2D5), .anchor_1D(anchor_1D5),
    .busy(busy5), .done(done5), .result(result5)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef CONV_RESULT_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'hBC00;
`endif
    exp_r5 = '{16'd0, 16'd0, 16'd2, 16'd2};
    exp_c5 = '{16'd0, 16'd2, 16'd0, 16'd2};

    step(); step();
    reset = 1'b0;
    step();
    chk("reset_conv_en", 64'(conv_en), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_anchors", {32'd0, anchor_2D, anchor_1D}, 64'd0);
    chk("reset_result", result, 64'd0);

    // pe_valid in IDLE must not write anything or start a pass
    pe_valid = 1'b1; pe_result = 16'h7777;
    step();
    pe_valid = 1'b0;
    step();
    chk("idle_valid_result", result, 64'd0);
    chk("idle_valid_conv_en", 64'(conv_en), 64'd0);

    // Test 1 with backpressure at (0,1) and start pulses while busy
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_conv_en", 64'(conv_en), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_anchor00", {32'd0, anchor_2D, anchor_1D}, {32'd0, 16'd0, 16'd0});
    pe_valid = 1'b1; pe_result = 16'h3C00; start = 1'b1;
    step();
    start = 1'b0; pe_valid = 1'b0;
    chk("t1_anchor01", {32'd0, anchor_2D, anchor_1D}, {32'd0, 16'd0, 16'd1});
    chk("t1_slot0", result, 64'h3C00_0000_0000_0000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_anchor01", {32'd0, anchor_2D, anchor_1D}, {32'd0, 16'd0, 16'd1});
      chk("bp_conv_en", 64'(conv_en), 64'd1);
      chk("bp_result", result, 64'h3C00_0000_0000_0000);
    end
    pe_valid = 1'b1; pe_result = 16'h4000; start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_anchor10", {32'd0, anchor_2D, anchor_1D}, {32'd0, 16'd1, 16'd0});
    pe_result = 16'h4200;
    step();
    chk("t1_anchor11", {32'd0, anchor_2D, anchor_1D}, {32'd0, 16'd1, 16'd1});
    chk("t1_done_low", 64'(done), 64'd0);
    pe_result = 16'h4400;
    step();
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_done_conv_en", 64'(conv_en), 64'd0);
    chk("t1_done_busy", 64'(busy), 64'd0);
    chk("t1_done_anchors", {32'd0, anchor_2D, anchor_1D}, 64'd0);
    chk("t1_result", result, 64'h3C00_4000_4200_4400);
    pe_result = 16'h1234; start = 1'b1;
    step();
    pe_valid = 1'b0; start = 1'b0;
    chk("t1_done_single", 64'(done), 64'd0);
    chk("t1_after_result", result, 64'h3C00_4000_4200_4400);
    chk("t1_after_idle", 64'(conv_en), 64'd0);
    step();
    chk("t1_hold_result", result, 64'h3C00_4000_4200_4400);

    // Test 6 then test 4: negative capture, then reset after the 2nd capture
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_cleared", result, 64'd0);
    pe_valid = 1'b1; pe_result = 16'hBC00;
    step();
    chk("t6_neg_slot0", result, {neg_exp, 48'd0});
    pe_result = 16'h4000;
    step();
    pe_valid = 1'b0;
    chk("t4_pre_anchor10", {32'd0, anchor_2D, anchor_1D}, {32'd0, 16'd1, 16'd0});
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t4_rst_conv_en", 64'(conv_en), 64'd0);
    chk("t4_rst_busy", 64'(busy), 64'd0);
    chk("t4_rst_done", 64'(done), 64'd0);
    chk("t4_rst_anchors", {32'd0, anchor_2D, anchor_1D}, 64'd0);
    chk("t4_rst_result", result, 64'd0);
    step();
    chk("t4_no_done", 64'(done), 64'd0);
    chk("t4_idle", 64'(conv_en), 64'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t4_restart_anchor", {32'd0, anchor_2D, anchor_1D}, 64'd0);
    chk("t4_restart_conv_en", 64'(conv_en), 64'd1);
    pe_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pe_result = 16'(i + 1);
      step();
    end
    pe_valid = 1'b0;
    chk("t4_restart_done", 64'(done), 64'd1);
    chk("t4_restart_result", result, 64'h0001_0002_0003_0004);

    // Test 2: 5x5 image, stride 2
    start5 = 1'b1;
    step();
    start5 = 1'b0;
    pe_valid5 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_anchor", {32'd0, anchor_2D5, anchor_1D5}, {32'd0, exp_r5[i], exp_c5[i]});
      chk("t2_done_low", 64'(done5), 64'd0);
      pe_result5 = 16'(16'h10 + i);
      step();
    end
    pe_valid5 = 1'b0;
    chk("t2_done", 64'(done5), 64'd1);
    chk("t2_result", result5, 64'h0010_0011_0012_0013);
    step();
    chk("t2_done_single", 64'(done5), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
